// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Architectural register file with per-register rename tags.
//               Optional same-cycle commit bypass: RF_COMMIT_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
  parameter int ROB_SIZE_BIT = 5,
  parameter int REG_NUM      = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    is_update_val,
  input  logic [4:0]              update_val_id,
  input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
  input  logic [31:0]             update_val,
  input  logic                    is_update_dep,
  input  logic [4:0]              update_dep_id,
  input  logic [ROB_SIZE_BIT-1:0] update_dep,
  input  logic [4:0]              qry1_reg_id,
  output logic                    qry1_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry1_dep,
  output logic [31:0]             qry1_value,
  input  logic [4:0]              qry2_reg_id,
  output logic                    qry2_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry2_dep,
  output logic [31:0]             qry2_value
);

  logic [31:0]             r_value [REG_NUM];
  logic [ROB_SIZE_BIT-1:0] r_dep   [REG_NUM];
  logic [REG_NUM-1:0]      r_busy;

  logic w_commit;
  logic w_alloc;
  logic w_commit_match;

  assign w_commit = rdy_in && !rob_clear && is_update_val && (update_val_id != 5'd0);
  assign w_alloc  = rdy_in && !rob_clear && is_update_dep && (update_dep_id != 5'd0);
  // Only the producer that currently owns the tag may release the register.
  assign w_commit_match = r_busy[update_val_id] && (r_dep[update_val_id] == update_val_dep);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_value[i] <= '0;
        r_dep[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (rob_clear) begin
        r_busy <= '0;
        for (int i = 0; i < REG_NUM; i++) begin
          r_dep[i] <= '0;
        end
      end else begin
        if (w_commit) begin
          r_value[update_val_id] <= update_val;
          if (w_commit_match) begin
            r_busy[update_val_id] <= 1'b0;
          end
        end
        // Placed after the commit so a same-register allocation overrides the release.
        if (w_alloc) begin
          r_busy[update_dep_id] <= 1'b1;
          r_dep[update_dep_id]  <= update_dep;
        end
      end
    end
  end

  always_comb begin
    qry1_has_dep = 1'b0;
    qry1_dep     = '0;
    qry1_value   = '0;
    if (qry1_reg_id != 5'd0) begin
      qry1_has_dep = r_busy[qry1_reg_id];
      qry1_dep     = r_busy[qry1_reg_id] ? r_dep[qry1_reg_id] : '0;
      qry1_value   = r_value[qry1_reg_id];
`ifdef RF_COMMIT_BYPASS_EN
      if (is_update_val && !rob_clear && (update_val_id == qry1_reg_id) && w_commit_match) begin
        qry1_has_dep = 1'b0;
        qry1_dep     = '0;
        qry1_value   = update_val;
      end
`endif
    end
  end

  always_comb begin
    qry2_has_dep = 1'b0;
    qry2_dep     = '0;
    qry2_value   = '0;
    if (qry2_reg_id != 5'd0) begin
      qry2_has_dep = r_busy[qry2_reg_id];
      qry2_dep     = r_busy[qry2_reg_id] ? r_dep[qry2_reg_id] : '0;
      qry2_value   = r_value[qry2_reg_id];
`ifdef RF_COMMIT_BYPASS_EN
      if (is_update_val && !rob_clear && (update_val_id == qry2_reg_id) && w_commit_match) begin
        qry2_has_dep = 1'b0;
        qry2_dep     = '0;
        qry2_value   = update_val;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Directed self-checking bench for reg_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

  localparam int RSB = 5;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           rdy_in;
  logic           rob_clear;
  logic           is_update_val;
  logic [4:0]     update_val_id;
  logic [RSB-1:0] update_val_dep;
  logic [31:0]    update_val;
  logic           is_update_dep;
  logic [4:0]     update_dep_id;
  logic [RSB-1:0] update_dep;
  logic [4:0]     qry1_reg_id;
  logic           qry1_has_dep;
  logic [RSB-1:0] qry1_dep;
  logic [31:0]    qry1_value;
  logic [4:0]     qry2_reg_id;
  logic           qry2_has_dep;
  logic [RSB-1:0] qry2_dep;
  logic [31:0]    qry2_value;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file #(.ROB_SIZE_BIT(RSB), .REG_NUM(32)) u_dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .rob_clear      (rob_clear),
    .is_update_val  (is_update_val),
    .update_val_id  (update_val_id),
    .update_val_dep (update_val_dep),
    .update_val     (update_val),
    .is_update_dep  (is_update_dep),
    .update_dep_id  (update_dep_id),
    .update_dep     (update_dep),
    .qry1_reg_id    (qry1_reg_id),
    .qry1_has_dep   (qry1_has_dep),
    .qry1_dep       (qry1_dep),
    .qry1_value     (qry1_value),
    .qry2_reg_id    (qry2_reg_id),
    .qry2_has_dep   (qry2_has_dep),
    .qry2_dep       (qry2_dep),
    .qry2_value     (qry2_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rob_clear     = 1'b0;
    is_update_val = 1'b0;
    is_update_dep = 1'b0;
  endtask

  task automatic commit(input logic [4:0] id, input logic [RSB-1:0] tag, input logic [31:0] v);
    is_update_val  = 1'b1;
    update_val_id  = id;
    update_val_dep = tag;
    update_val     = v;
  endtask

  task automatic alloc(input logic [4:0] id, input logic [RSB-1:0] tag);
    is_update_dep = 1'b1;
    update_dep_id = id;
    update_dep    = tag;
  endtask

  task automatic query(input logic [4:0] r1, input logic [4:0] r2);
    qry1_reg_id = r1;
    qry2_reg_id = r2;
    #1;
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    idle();
    update_val_id = '0; update_val_dep = '0; update_val = '0;
    update_dep_id = '0; update_dep = '0;
    qry1_reg_id = 5'd5;
    qry2_reg_id = 5'd0;
    #12;
    check("rst_q1_has_dep", 32'(qry1_has_dep), 32'd0);
    check("rst_q1_dep",     32'(qry1_dep),     32'd0);
    check("rst_q1_value",   qry1_value,        32'd0);
    check("rst_q2_x0_val",  qry2_value,        32'd0);
    check("rst_q2_x0_dep",  32'(qry2_has_dep), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();

    // x0 ignores commits and allocations
    commit(5'd0, 5'd0, 32'h1234);
    alloc(5'd0, 5'd1);
    tick(); idle();
    query(5'd0, 5'd0);
    check("x0_value",   qry1_value,        32'd0);
    check("x0_has_dep", 32'(qry2_has_dep), 32'd0);

    // allocation invisible in the same cycle
    alloc(5'd3, 5'd7);
    query(5'd3, 5'd3);
    check("x3_same_cycle_has_dep", 32'(qry1_has_dep), 32'd0);
    tick(); idle();
    query(5'd3, 5'd0);
    check("x3_has_dep", 32'(qry1_has_dep), 32'd1);
    check("x3_dep7",    32'(qry1_dep),     32'd7);

    // stale commit writes value but keeps newer tag
    alloc(5'd3, 5'd9);
    tick(); idle();
    commit(5'd3, 5'd7, 32'hAA);
    tick(); idle();
    query(5'd3, 5'd0);
    check("x3_stale_value",   qry1_value,        32'hAA);
    check("x3_stale_has_dep", 32'(qry1_has_dep), 32'd1);
    check("x3_stale_dep9",    32'(qry1_dep),     32'd9);
    commit(5'd3, 5'd9, 32'hBB);
    tick(); idle();
    query(5'd3, 5'd0);
    check("x3_final_has_dep", 32'(qry1_has_dep), 32'd0);
    check("x3_final_value",   qry1_value,        32'hBB);

    // same-cycle commit + allocation to one register
    alloc(5'd4, 5'd2);
    tick(); idle();
    commit(5'd4, 5'd2, 32'h55);
    alloc(5'd4, 5'd3);
    tick(); idle();
    query(5'd4, 5'd0);
    check("x4_has_dep", 32'(qry1_has_dep), 32'd1);
    check("x4_dep3",    32'(qry1_dep),     32'd3);
    check("x4_value",   qry1_value,        32'h55);

    // flush drops tags, ignores same-cycle commit/alloc
    commit(5'd1, 5'd12, 32'h11);
    tick(); idle();
    alloc(5'd1, 5'd10);
    tick(); idle();
    alloc(5'd2, 5'd11);
    tick(); idle();
    query(5'd1, 5'd2);
    check("pre_clr_x1_busy", 32'(qry1_has_dep), 32'd1);
    check("pre_clr_x2_dep",  32'(qry2_dep),     32'd11);
    rob_clear = 1'b1;
    commit(5'd1, 5'd10, 32'h77);
    alloc(5'd6, 5'd13);
    tick(); idle();
    query(5'd1, 5'd2);
    check("clr_x1_has_dep", 32'(qry1_has_dep), 32'd0);
    check("clr_x1_value",   qry1_value,        32'h11);
    check("clr_x2_has_dep", 32'(qry2_has_dep), 32'd0);
    query(5'd6, 5'd4);
    check("clr_x6_has_dep", 32'(qry1_has_dep), 32'd0);
    check("clr_x4_has_dep", 32'(qry2_has_dep), 32'd0);
    check("clr_x4_value",   qry2_value,        32'h55);

    // rdy_in low freezes state
    rdy_in = 1'b0;
    alloc(5'd7, 5'd5);
    commit(5'd7, 5'd5, 32'h99);
    tick(); idle();
    rdy_in = 1'b1;
    query(5'd7, 5'd0);
    check("stall_x7_has_dep", 32'(qry1_has_dep), 32'd0);
    check("stall_x7_value",   qry1_value,        32'd0);

    // same-cycle commit with matching tag
    alloc(5'd8, 5'd4);
    tick(); idle();
    commit(5'd8, 5'd4, 32'hDEAD);
    query(5'd8, 5'd8);
`ifdef RF_COMMIT_BYPASS_EN
    check("byp_q1_has_dep", 32'(qry1_has_dep), 32'd0);
    check("byp_q1_value",   qry1_value,        32'hDEAD);
    check("byp_q2_dep",     32'(qry2_dep),     32'd0);
`else
    check("byp_q1_has_dep", 32'(qry1_has_dep), 32'd1);
    check("byp_q1_dep",     32'(qry1_dep),     32'd4);
    check("byp_q2_has_dep", 32'(qry2_has_dep), 32'd1);
`endif
    tick(); idle();
    query(5'd8, 5'd0);
    check("x8_has_dep", 32'(qry1_has_dep), 32'd0);
    check("x8_value",   qry1_value,        32'hDEAD);

    // same-cycle commit with mismatched tag is never bypassed
    alloc(5'd9, 5'd6);
    tick(); idle();
    commit(5'd9, 5'd5, 32'hBEEF);
    query(5'd0, 5'd9);
    check("nobyp_has_dep", 32'(qry2_has_dep), 32'd1);
    check("nobyp_dep6",    32'(qry2_dep),     32'd6);
    check("nobyp_value",   qry2_value,        32'd0);
    tick(); idle();
    query(5'd0, 5'd9);
    check("x9_value",   qry2_value,        32'hBEEF);
    check("x9_has_dep", 32'(qry2_has_dep), 32'd1);

    // asynchronous reset clears everything mid-cycle
    #2;
    rst_in = 1'b0;
    query(5'd8, 5'd9);
    check("arst_x8_value",   qry1_value,        32'd0);
    check("arst_x9_has_dep", 32'(qry2_has_dep), 32'd0);
    rst_in = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
